// File: rtl/bsg_downstream_token_and_data.sv
// rtl/bsg_downstream_token_and_data.sv - link receive side: beat reassembly, word FIFO, credit token return
// Optional beat parity checking is built only when BSG_DOWNSTREAM_PARITY_EN is defined.
module bsg_downstream_token_and_data #(
    parameter int CH_WIDTH    = 8,
    parameter int CORE_WIDTH  = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int TOKEN_BATCH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  io_valid_in,
    input  logic [CH_WIDTH-1:0]   io_data_in_ch0,
    input  logic [CH_WIDTH-1:0]   io_data_in_ch1,
    input  logic                  io_parity_in,
    output logic                  io_token_out,
    output logic [CORE_WIDTH-1:0] core_data_out,
    output logic                  core_valid_out,
    input  logic                  core_ready_in,
    output logic                  overflow_err,
    output logic                  parity_err
);

    localparam int BEAT_W     = 2 * CH_WIDTH;
    localparam int BEATS      = CORE_WIDTH / BEAT_W;
    localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int PTR_W      = ADDR_W + 1;
    localparam int POP_W      = $clog2(TOKEN_BATCH) + 1;

    logic [BEAT_IDX_W-1:0] beat_cnt;
    logic [CORE_WIDTH-1:0] asm_word;
    logic                  push_pending;
    logic [BEAT_W-1:0]     beat;

    logic [CORE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  do_pop;
    logic                  do_push;
    logic                  drop;

    logic [POP_W-1:0]      pop_cnt;
    logic                  token_q;
    logic                  overflow_q;

    assign beat = {io_data_in_ch1, io_data_in_ch0};

    // Beat assembly: the completed word is handed to the FIFO one cycle after its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            asm_word     <= '0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            if (io_valid_in) begin
                asm_word[32'(beat_cnt) * BEAT_W +: BEAT_W] <= beat;
                if (beat_cnt == BEAT_IDX_W'(BEATS - 1)) begin
                    beat_cnt     <= '0;
                    push_pending <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_IDX_W'(1);
                end
            end
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop     = !fifo_empty && core_ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the word.
    assign do_push    = push_pending && (!fifo_full || do_pop);
    assign drop       = push_pending && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= asm_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign core_valid_out = !fifo_empty;
    assign core_data_out  = fifo_empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Credit return: one pulse per TOKEN_BATCH words consumed by the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_cnt <= '0;
            token_q <= 1'b0;
        end else begin
            token_q <= 1'b0;
            if (do_pop) begin
                if (pop_cnt == POP_W'(TOKEN_BATCH - 1)) begin
                    pop_cnt <= '0;
                    token_q <= 1'b1;
                end else begin
                    pop_cnt <= pop_cnt + POP_W'(1);
                end
            end
        end
    end

    assign io_token_out = token_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_err = overflow_q;

`ifdef BSG_DOWNSTREAM_PARITY_EN
    logic parity_q;

    // Odd parity: the XOR of both channels and the parity bit must be 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (io_valid_in && !(^{beat, io_parity_in})) begin
            parity_q <= 1'b1;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0 & io_parity_in;
`endif

endmodule

// File: tb/tb_bsg_downstream_token_and_data.sv
// tb/tb_bsg_downstream_token_and_data.sv - randomized self-checking bench against a queue-based reference model
module tb_bsg_downstream_token_and_data;

    localparam int CH_WIDTH    = 8;
    localparam int CORE_WIDTH  = 64;
    localparam int FIFO_DEPTH  = 16;
    localparam int TOKEN_BATCH = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  io_valid_in;
    logic [CH_WIDTH-1:0]   io_data_in_ch0;
    logic [CH_WIDTH-1:0]   io_data_in_ch1;
    logic                  io_parity_in;
    logic                  io_token_out;
    logic [CORE_WIDTH-1:0] core_data_out;
    logic                  core_valid_out;
    logic                  core_ready_in;
    logic                  overflow_err;
    logic                  parity_err;

    bsg_downstream_token_and_data #(
        .CH_WIDTH    (CH_WIDTH),
        .CORE_WIDTH  (CORE_WIDTH),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TOKEN_BATCH (TOKEN_BATCH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_valid_in    (io_valid_in),
        .io_data_in_ch0 (io_data_in_ch0),
        .io_data_in_ch1 (io_data_in_ch1),
        .io_parity_in   (io_parity_in),
        .io_token_out   (io_token_out),
        .core_data_out  (core_data_out),
        .core_valid_out (core_valid_out),
        .core_ready_in  (core_ready_in),
        .overflow_err   (overflow_err),
        .parity_err     (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tok_seen = 0;

    logic [15:0] m_beats [$];
    logic [63:0] m_fifo  [$];
    bit          m_pend;
    logic [63:0] m_pend_word;
    int          m_pops;
    bit          m_tok;
    bit          m_ovf;
    bit          m_par;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_fifo.delete();
        m_pend = 0;
        m_pend_word = '0;
        m_pops = 0;
        m_tok = 0;
        m_ovf = 0;
        m_par = 0;
    endtask

    // One clock edge of the reference: pop, then deliver the pending word, then capture the beat.
    task automatic model_edge();
        bit          ntok;
        logic [15:0] b;
        ntok = 0;
        if (m_fifo.size() > 0 && core_ready_in) begin
            void'(m_fifo.pop_front());
            m_pops++;
            if (m_pops == TOKEN_BATCH) begin
                m_pops = 0;
                ntok = 1;
            end
        end
        if (m_pend) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pend_word);
            else m_ovf = 1;
        end
        m_pend = 0;
        if (io_valid_in) begin
            b = {io_data_in_ch1, io_data_in_ch0};
`ifdef BSG_DOWNSTREAM_PARITY_EN
            if ((^b ^ io_parity_in) != 1'b1) m_par = 1;
`endif
            m_beats.push_back(b);
            if (m_beats.size() == 4) begin
                m_pend_word = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
                m_pend = 1;
                m_beats.delete();
            end
        end
        m_tok = ntok;
    endtask

    task automatic compare_all();
        check("valid", core_valid_out, m_fifo.size() > 0);
        check("data", core_data_out, (m_fifo.size() > 0) ? m_fifo[0] : 64'h0);
        check("token", io_token_out, m_tok);
        check("overflow", overflow_err, m_ovf);
        check("parity", parity_err, m_par);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (io_token_out) tok_seen++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        tok_seen = 0;
    endtask

    task automatic send_beat(input logic [15:0] b, input bit bad);
        io_valid_in    = 1'b1;
        io_data_in_ch0 = b[7:0];
        io_data_in_ch1 = b[15:8];
        io_parity_in   = bad ? (^b) : ~(^b);
        step();
        io_valid_in    = 1'b0;
        io_data_in_ch0 = '0;
        io_data_in_ch1 = '0;
        io_parity_in   = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input int min_idle, input int max_idle, input int bad_beat);
        int idle;
        for (int k = 0; k < 4; k++) begin
            send_beat(w[16*k +: 16], bad_beat == k);
            idle = (k == 3) ? 0 : int'($urandom_range(max_idle, min_idle));
            for (int i = 0; i < idle; i++) step();
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [63:0] w;

    initial begin
        rst_n          = 1'b0;
        io_valid_in    = 1'b0;
        io_data_in_ch0 = '0;
        io_data_in_ch1 = '0;
        io_parity_in   = 1'b0;
        core_ready_in  = 1'b0;
        model_reset();

        // Single word with no gaps, then with 1..3 idle cycles between beats
        do_reset();
        send_word(64'h8877665544332211, 0, 0, -1);
        check("t1_not_yet_valid", core_valid_out, 1'b0);
        step();
        check("t1_word", core_data_out, 64'h8877665544332211);
        check("t1_valid", core_valid_out, 1'b1);
        send_word(64'h8877665544332211, 1, 3, -1);
        idle_steps(2);
        core_ready_in = 1'b1;
        idle_steps(2);
        check("t2_one_extra_word_only", core_valid_out, 1'b0);
        idle_steps(1);

        // Token pulses with the core always ready
        do_reset();
        core_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) send_word({$urandom, $urandom}, 0, 0, -1);
        idle_steps(4);
        check("t3_token_count", tok_seen, 2);

        // Fill the FIFO, overflow with a 17th word, then drain in order
        do_reset();
        core_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) send_word({$urandom, $urandom}, 0, 1, -1);
        idle_steps(2);
        check("t4_full_no_token", tok_seen, 0);
        send_word(64'hdead_beef_0000_0017, 0, 0, -1);
        idle_steps(2);
        check("t4_overflow", overflow_err, 1'b1);
        core_ready_in = 1'b1;
        idle_steps(20);
        check("t4_drained", core_valid_out, 1'b0);

        // 17th word lands on the same edge as a pop: no overflow
        do_reset();
        core_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) send_word({$urandom, $urandom}, 0, 0, -1);
        idle_steps(2);
        send_word(64'h1717_1717_1717_1717, 0, 0, -1);
        core_ready_in = 1'b1;
        step();
        core_ready_in = 1'b0;
        idle_steps(2);
        check("t5_no_overflow", overflow_err, 1'b0);
        core_ready_in = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("t5_last_word", core_data_out, 64'h1717_1717_1717_1717);
        idle_steps(3);

        // Reset mid-word discards the partial word
        do_reset();
        core_ready_in = 1'b0;
        send_beat(16'haaaa, 1'b0);
        send_beat(16'hbbbb, 1'b0);
        do_reset();
        send_word(64'h0123_4567_89ab_cdef, 0, 2, -1);
        step();
        check("t6_fresh_word", core_data_out, 64'h0123_4567_89ab_cdef);
`ifdef BSG_DOWNSTREAM_PARITY_EN
        send_word(64'hfeed_face_cafe_f00d, 0, 0, 1);
        step();
        check("t6_parity_err", parity_err, 1'b1);
`endif
        core_ready_in = 1'b1;
        idle_steps(4);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            io_valid_in    = ($urandom_range(3, 0) != 0);
            io_data_in_ch0 = CH_WIDTH'($urandom);
            io_data_in_ch1 = CH_WIDTH'($urandom);
            io_parity_in   = ($urandom_range(31, 0) == 0) ? ^{io_data_in_ch1, io_data_in_ch0}
                                                          : ~(^{io_data_in_ch1, io_data_in_ch0});
            core_ready_in  = ($urandom_range(2, 0) != 0);
            if (c % 200 == 199) begin
                io_valid_in = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
